// File: rtl/anti_theft_pkg.sv
// Shared definitions for the anti-theft timer and the system FSM that drives it.
package anti_theft_pkg;

  localparam int unsigned SEL_W      = 2;
  localparam int unsigned TIME_W     = 4;
  localparam int unsigned NUM_PARAMS = 4;

  localparam logic [SEL_W-1:0] INT_ARM       = 2'b00;
  localparam logic [SEL_W-1:0] INT_DRIVER    = 2'b01;
  localparam logic [SEL_W-1:0] INT_PASSENGER = 2'b10;
  localparam logic [SEL_W-1:0] INT_ALARM     = 2'b11;

  localparam logic [TIME_W-1:0] DEF_ARM_DELAY       = 4'd6;
  localparam logic [TIME_W-1:0] DEF_DRIVER_DELAY    = 4'd8;
  localparam logic [TIME_W-1:0] DEF_PASSENGER_DELAY = 4'd15;
  localparam logic [TIME_W-1:0] DEF_ALARM_ON        = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } timer_state_t;

  function automatic logic [TIME_W-1:0] default_time(input logic [SEL_W-1:0] sel);
    case (sel)
      INT_ARM:       default_time = DEF_ARM_DELAY;
      INT_DRIVER:    default_time = DEF_DRIVER_DELAY;
      INT_PASSENGER: default_time = DEF_PASSENGER_DELAY;
      default:       default_time = DEF_ALARM_ON;
    endcase
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// Free-running prescaler producing a one-cycle enable every CLK_DIV clocks.
module one_hz_divider #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic one_hz_enable
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (clear || cnt == LAST) cnt_next = '0;
  end

  // Enable is registered from the next count so it is high while cnt == LAST.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      one_hz_enable <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      one_hz_enable <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/anti_theft_timer.sv
// Programmable delay store plus countdown timer for the anti-theft system FSM.
module anti_theft_timer
  import anti_theft_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SEL_W-1:0]  time_param_sel,
  input  logic [TIME_W-1:0] time_value,
  input  logic              reprogram,
  input  logic              start_timer,
  input  logic [SEL_W-1:0]  interval,
  output logic              expired,
  output logic              one_hz_enable,
  output logic [TIME_W-1:0] seconds_left
);

  logic [TIME_W-1:0] param [NUM_PARAMS];

  timer_state_t      state, state_next;
  logic [TIME_W-1:0] count, count_next;
  logic [SEL_W-1:0]  latched, latched_next;
  logic [TIME_W-1:0] load_value;
  logic              load;
  logic              expired_next;
  logic [TIME_W-1:0] seconds_next;

  assign load_value = param[interval];

  one_hz_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clock         (clock),
    .reset         (reset),
    .clear         (reprogram | load),
    .one_hz_enable (one_hz_enable)
  );

  // State, counter, output and parameter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      latched      <= INT_ARM;
      expired      <= 1'b0;
      seconds_left <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) param[i] <= default_time(SEL_W'(i));
    end else begin
      state        <= state_next;
      count        <= count_next;
      latched      <= latched_next;
      expired      <= expired_next;
      seconds_left <= seconds_next;
      if (reprogram) param[time_param_sel] <= time_value;
    end
  end

  // Next state; priority is reprogram > start low > interval change > tick.
  always_comb begin
    state_next   = state;
    count_next   = count;
    latched_next = latched;
    load         = 1'b0;
    if (reprogram) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_timer) load = 1'b1;
        end
        ST_COUNT: begin
          if (!start_timer) state_next = ST_IDLE;
          else if (interval != latched) load = 1'b1;
          else if (one_hz_enable && count != '0) begin
            count_next = count - TIME_W'(1);
            if (count == TIME_W'(1)) state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start_timer) state_next = ST_IDLE;
          else if (interval != latched) load = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
    if (load) begin
      latched_next = interval;
      count_next   = load_value;
      state_next   = (load_value == '0) ? ST_DONE : ST_COUNT;
    end
  end

  // Output values presented after the next edge.
  always_comb begin
    expired_next = (state_next == ST_DONE);
    seconds_next = (state_next == ST_COUNT) ? count_next : '0;
  end

endmodule

// File: tb/tb_anti_theft_timer.sv
// Randomized scoreboard bench for anti_theft_timer with an elapsed-time reference model.
module tb_anti_theft_timer;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       reprogram;
  logic       start_timer;
  logic [1:0] interval;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] seconds_left;

  anti_theft_timer #(.CLK_DIV(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .reprogram      (reprogram),
    .start_timer    (start_timer),
    .interval       (interval),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .seconds_left   (seconds_left)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit ex;
    bit hz;
    int secs;
  } expect_t;

  expect_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: time since load / since last prescaler clear, in cycles.
  int par [4];
  int n, clr_cyc, load_cyc, t_load, latched;
  bit run;

  task automatic model_reset();
    par[0] = 6; par[1] = 8; par[2] = 15; par[3] = 10;
    n = 0; clr_cyc = 0; run = 0; load_cyc = 0; t_load = 0; latched = 0;
  endtask

  task automatic model_load(input int iv);
    latched  = iv;
    t_load   = par[iv];
    load_cyc = n;
    clr_cyc  = n;
    run      = 1;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input bit rp, input int sel, input int val, input bit st, input int iv);
    expect_t e;
    int el;
    @(negedge clock);
    reprogram      = rp;
    time_param_sel = 2'(sel);
    time_value     = 4'(val);
    start_timer    = st;
    interval       = 2'(iv);
    n++;
    if (rp) begin
      par[sel] = val;
      run      = 0;
      clr_cyc  = n;
    end else if (!run) begin
      if (st) model_load(iv);
    end else if (!st) begin
      run = 0;
    end else if (iv != latched) begin
      model_load(iv);
    end
    e.ex = 0; e.secs = 0;
    if (run) begin
      el = n - load_cyc;
      if (el >= t_load * D) e.ex = 1;
      else e.secs = t_load - el / D;
    end
    e.hz = (((n - clr_cyc) % D) == D - 1);
    sb.push_back(e);
    @(posedge clock);
  endtask

  task automatic hold(input int cycles, input bit st, input int iv);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, st, iv);
  endtask

  task automatic apply_reset();
    reprogram = 0; start_timer = 0; interval = 0; time_param_sel = 0; time_value = 0;
    reset = 1;
    repeat (3) @(posedge clock);
    #2;
    reset = 0;
    model_reset();
  endtask

  // Monitor: outputs are valid every cycle, compared just after the edge.
  always @(posedge clock) begin
    expect_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("expired", int'(expired), int'(e.ex));
      check("one_hz_enable", int'(one_hz_enable), int'(e.hz));
      check("seconds_left", int'(seconds_left), e.secs);
    end
  end

  initial begin
    bit st;
    int iv;
    model_reset();
    apply_reset();
    #1;
    check("reset_expired", int'(expired), 0);
    check("reset_hz", int'(one_hz_enable), 0);
    check("reset_secs", int'(seconds_left), 0);

    // Arm delay countdown, then release.
    hold(30, 1, 0);
    hold(3, 0, 0);
    // Driver delay aborted after 10 cycles, then a full restart.
    hold(10, 1, 1);
    hold(2, 0, 1);
    hold(36, 1, 1);
    hold(2, 0, 1);
    // Passenger delay then switch to alarm with start held.
    hold(62, 1, 2);
    hold(45, 1, 3);
    hold(2, 0, 3);
    // Reprogrammed driver delay of 3 s.
    step(1, 1, 3, 0, 0);
    hold(16, 1, 1);
    hold(2, 0, 1);
    // Zero arm delay expires at the load edge.
    step(1, 0, 0, 0, 0);
    hold(3, 1, 0);
    hold(2, 0, 0);
    // Reprogram wins over a same-cycle start.
    step(1, 0, 5, 1, 0);
    hold(2, 0, 0);
    // Mid-count asynchronous reset between edges.
    step(1, 2, 7, 0, 0);
    hold(13, 1, 2);
    #2;
    reset = 1;
    #1;
    check("async_reset_expired", int'(expired), 0);
    check("async_reset_hz", int'(one_hz_enable), 0);
    check("async_reset_secs", int'(seconds_left), 0);
    apply_reset();
    // Defaults restored: run every interval to expiry.
    for (int k = 0; k < 4; k++) begin
      hold(64, 1, k);
      hold(2, 0, k);
    end

    st = 0; iv = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 4) st = ~st;
      if ($urandom_range(0, 99) < 3) iv = int'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 3), int'($urandom_range(0, 3)),
           int'($urandom_range(1, 15)), st, iv);
    end
    hold(2, 0, 0);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anti_theft_timer.md
# anti_theft_timer

Programmable time-parameter store and countdown timer for the automotive anti-theft system. It holds the four user-programmable delays, generates the system 1 Hz enable and runs the countdown requested by the system FSM through `start_timer`/`interval`. It returns `expired` to the FSM and `seconds_left` to the display logic.

## Interface
- `CLK_DIV`, default 50_000_000: clock cycles per one_hz_enable pulse; must be ≥ 2.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `time_param_sel`  in  2  parameter to program: 00 T_ARM_DELAY, 01 T_DRIVER_DELAY, 10 T_PASSENGER_DELAY, 11 T_ALARM_ON.
- `time_value`  in  4  new value for the selected parameter, in seconds.
- `reprogram`  in  1  synchronous pulse: write the selected parameter and abort any countdown.
- `start_timer`  in  1  level from the FSM: countdown requested while high.
- `interval`  in  2  parameter to count; uses the same encoding as time_param_sel.
- `expired`  out  1  the countdown of the latched interval has finished.
- `one_hz_enable`  out  1  one-cycle pulse every CLK_DIV cycles.
- `seconds_left`  out  4  remaining seconds. It reads 0 when idle.

## Operation
- Parameter registers have the following reset defaults: T_ARM_DELAY=6, T_DRIVER_DELAY=8, T_PASSENGER_DELAY=15, T_ALARM_ON=10.
- When `reprogram` is high:
  - `time_value` is written into `param[time_param_sel]`. A value of 0 is stored as written.
  - The FSM goes to IDLE, `expired` is cleared and the prescaler is cleared.
  - `reprogram` has priority over every other event in the same cycle.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - `one_hz_enable` is high in the cycle the count equals CLK_DIV-1.
  - The prescaler is cleared to 0 on every load.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - `start_timer`=1 causes a load: `latched_interval`←`interval`, `count`←`param[interval]`, prescaler←0.
  - If the loaded value is 0, the next state is DONE; otherwise it is COUNT.
- COUNT:
  - `start_timer`=0 → IDLE.
  - `interval`≠`latched_interval` → reload from the new interval (restart), staying in COUNT or going to DONE per the rule above.
  - Otherwise, on `one_hz_enable`, `count` decrements; if `count` was 1, the next state is DONE.
- DONE:
  - `expired`=1 is held.
  - `start_timer`=0 → IDLE.
  - `interval`≠`latched_interval` → reload, with `expired` low from the next cycle. This supports a continuous `start_timer` across TRIGGERED→ACTIVATE_ALARM.
- Priority within a cycle: reprogram > start_timer low > interval change > tick.
- Parameter writes during a countdown do not affect the value already loaded. They take effect at the next load.
- `seconds_left` equals `count` in COUNT and is 0 in IDLE and DONE.
- `count` never decrements below 0. The decrement applies only in COUNT with `count`≥1.

## Timing
- Reset values: `expired`=0, `one_hz_enable`=0, `seconds_left`=0, state IDLE, prescaler 0, parameters at their defaults.
- All outputs are registered. There is no combinational path from any input to any output.
- A load occurs at the edge where IDLE samples `start_timer`=1. `expired` rises exactly T×CLK_DIV cycles after the load edge, where T=`param[latched_interval]` and T≥1.
- With T=0, `expired` rises at the load edge.
- `seconds_left` shows T in the cycle after the load and steps down by 1 at each tick edge.
- `expired` falls in the cycle after `start_timer` is sampled low, or after an interval change or reprogram is sampled.
- An asserted `reset` in mid-count forces all reset values immediately, independent of `clock`.

## Structure
- Shared package `anti_theft_pkg` holds:
  - Interval codes (`INT_ARM`, `INT_DRIVER`, `INT_PASSENGER`, `INT_ALARM`), shared with the system FSM.
  - Default times.
  - The timer state encoding.
- Sub-module `one_hz_divider`, parameterised by CLK_DIV, with a synchronous clear input. It drives `one_hz_enable`.
- The top level contains the parameter register file, the load mux, the countdown FSM and the down-counter.

## Test plan
CLK_DIV=4 in all scenarios.
- Reset, then `start_timer`=1 with `interval`=00 → `seconds_left` shows 6,5,…,1 at 4-cycle steps. `expired` rises 24 cycles after the load and holds until `start_timer`=0. It falls one cycle after `start_timer`=0.
- Program `time_param_sel`=01, `time_value`=3 with a `reprogram` pulse, then start with `interval`=01 → `expired` rises 12 cycles after the load.
- Start with `interval`=10 and wait for `expired` (60 cycles). Then switch to `interval`=11 with `start_timer` held → `expired` goes low next cycle and rises again 40 cycles after the reload.
- Start with `interval`=01 and drop `start_timer` after 10 cycles → IDLE, `expired`=0, `seconds_left`=0. A restart counts the full 8 s (32 cycles).
- Program 0 into T_ARM_DELAY and start with `interval`=00 → `expired`=1 in the cycle after the load. A `reprogram` pulse in the same cycle as `start_timer` leaves the block in IDLE.
- Assert `reset` in mid-count and between clock edges → all outputs are 0 at once. Parameters return to 6/8/15/10 even after earlier programming.
